mem_sequencer: RTL and testbench

Memory-access sequencer between the microprogrammed control unit and a byte-wide synchronous RAM. It accepts a request on the MFA/R/W/MAS control signals and executes a byte, halfword or word transfer as 1, 2 or 4 byte beats in big-endian order. It returns MFC using a four-phase handshake, which the microcode waits on. Misaligned and reserved-size requests are rejected with an error flag and perform no RAM access.

---
 rtl/mem_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// Memory-access sequencer: turns MFA/R/W/MAS requests from the microcode into
// big-endian byte beats on a byte-wide synchronous RAM, answering with MFC.
module mem_sequencer #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mfa,
   input  logic              rw,
   input  logic [1:0]        mas,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              mfc,
   output logic              err,
   output logic              busy,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

   state_t            state_reg, state_next;
   logic              rw_reg, err_reg, err_pend_reg;
   logic [2:0]        n_reg, cnt_reg;
   logic [23:0]       wshift_reg, rshift_reg;
   logic [31:0]       rdata_reg;
   logic [ADDR_W-1:0] ram_addr_reg;
   logic [7:0]        ram_wdata_reg;

   logic              req_bad, xfer_last, beat_more;
   logic [2:0]        req_n;
   logic [31:0]       req_aligned;
   logic              unused_addr_hi;

   // High address bits alias onto the RAM.
   assign unused_addr_hi = ^addr[31:ADDR_W];

   // Request decode; write data is left-aligned so beats always shift out of the top byte.
   always_comb begin
      req_bad     = 1'b0;
      req_n       = 3'd4;
      req_aligned = wdata;
      case (mas)
         2'b00: begin
            req_n       = 3'd1;
            req_aligned = {wdata[7:0], 24'h000000};
         end
         2'b01: begin
            req_n       = 3'd2;
            req_aligned = {wdata[15:0], 16'h0000};
            req_bad     = addr[0];
         end
         2'b10: begin
            req_n       = 3'd4;
            req_bad     = |addr[1:0];
         end
         default: req_bad = 1'b1;
      endcase
   end

   // Reads spend one extra cycle in XFER to capture the final registered RAM byte.
   assign xfer_last = (cnt_reg == (rw_reg ? n_reg : n_reg - 3'd1));
   assign beat_more = (cnt_reg + 3'd1) < n_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (err_pend_reg)          state_next = DONE;
            else if (mfa && !req_bad)  state_next = XFER;
         end
         XFER:    if (xfer_last) state_next = DONE;
         DONE:    if (!mfa)      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mfc       = (state_reg == DONE);
      busy      = (state_reg == XFER);
      ram_en    = (state_reg == XFER) && (cnt_reg < n_reg);
      ram_we    = ram_en && !rw_reg;
      err       = err_reg;
      rdata     = rdata_reg;
      ram_addr  = ram_addr_reg;
      ram_wdata = ram_wdata_reg;
   end

   // A rejected request idles one cycle (err_pend_reg) before raising MFC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_reg        <= 1'b0;
         err_reg       <= 1'b0;
         err_pend_reg  <= 1'b0;
         n_reg         <= 3'd0;
         cnt_reg       <= 3'd0;
         wshift_reg    <= 24'h000000;
         rshift_reg    <= 24'h000000;
         rdata_reg     <= 32'h00000000;
         ram_addr_reg  <= '0;
         ram_wdata_reg <= 8'h00;
      end else begin
         case (state_reg)
            IDLE: begin
               if (err_pend_reg) begin
                  err_pend_reg <= 1'b0;
               end else if (mfa) begin
                  rw_reg       <= rw;
                  n_reg        <= req_n;
                  cnt_reg      <= 3'd0;
                  err_reg      <= req_bad;
                  err_pend_reg <= req_bad;
                  rshift_reg   <= 24'h000000;
                  if (!req_bad) begin
                     ram_addr_reg  <= addr[ADDR_W-1:0];
                     ram_wdata_reg <= req_aligned[31:24];
                     wshift_reg    <= req_aligned[23:0];
                  end
               end
            end
            XFER: begin
               cnt_reg <= cnt_reg + 3'd1;
               if (beat_more) begin
                  ram_addr_reg  <= ram_addr_reg + ADDR_W'(1);
                  ram_wdata_reg <= wshift_reg[23:16];
                  wshift_reg    <= {wshift_reg[15:0], 8'h00};
               end
               // Byte for beat k arrives in cycle k+1; rdata only updates on the last capture.
               if (rw_reg && cnt_reg != 3'd0) begin
                  rshift_reg <= {rshift_reg[15:0], ram_rdata};
                  if (xfer_last) rdata_reg <= {rshift_reg, ram_rdata};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: per-cycle check against a transaction-level timeline
// model, directed literal cases, then randomized requests.
module tb_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mfa = 1'b0;
   logic        rw = 1'b0;
   logic [1:0]  mas = 2'b00;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        mfc, err, busy, ram_en, ram_we;
   logic [8:0]  ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        ram_load = 1'b1;
   logic [7:0]  ram [512];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_sequencer #(.ADDR_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .mfa(mfa), .rw(rw), .mas(mas), .addr(addr),
      .wdata(wdata), .rdata(rdata), .mfc(mfc), .err(err), .busy(busy),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Byte-wide RAM with registered read.
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 512; i++) ram[i] <= 8'(i) ^ 8'h5A;
         ram_rdata <= 8'h00;
      end else if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         ram_rdata <= ram[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted request becomes a queue of expected cycles.
   typedef struct packed {
      logic       bsy;
      logic       en;
      logic       we;
      logic [8:0] a;
      logic [7:0] d;
   } cyc_t;

   cyc_t        q[$];
   cyc_t        mc;
   logic [7:0]  gold [512];
   logic        mdl_done, mdl_rd, exp_err, m_bad;
   logic [31:0] exp_rdata, pend_rdata;
   int          m_n;
   logic [8:0]  m_base;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mdl_done   = 1'b0;
         mdl_rd     = 1'b0;
         exp_err    = 1'b0;
         exp_rdata  = 32'h0;
         pend_rdata = 32'h0;
         if (ram_load) for (int i = 0; i < 512; i++) gold[i] = 8'(i) ^ 8'h5A;
      end else if (q.size() > 0) begin
         mc = q.pop_front();
         if (mc.en && mc.we) gold[mc.a] = mc.d;
         if (q.size() == 0) begin
            mdl_done = 1'b1;
            if (mdl_rd) exp_rdata = pend_rdata;
         end
      end else if (mdl_done) begin
         if (!mfa) mdl_done = 1'b0;
      end else if (mfa) begin
         m_n    = (mas == 2'd0) ? 1 : (mas == 2'd1) ? 2 : 4;
         m_bad  = (mas == 2'd3) || (mas == 2'd1 && addr[0]) || (mas == 2'd2 && addr[1:0] != 2'd0);
         exp_err = m_bad;
         mdl_rd  = rw && !m_bad;
         if (m_bad) begin
            q.push_back(cyc_t'{bsy: 1'b0, en: 1'b0, we: 1'b0, a: 9'd0, d: 8'd0});
         end else begin
            m_base     = addr[8:0];
            pend_rdata = 32'h0;
            for (int k = 0; k < m_n; k++) begin
               q.push_back(cyc_t'{bsy: 1'b1, en: 1'b1, we: ~rw, a: 9'(m_base + k),
                                  d: 8'(wdata >> (8 * (m_n - 1 - k)))});
               pend_rdata = pend_rdata | (32'(gold[9'(m_base + k)]) << (8 * (m_n - 1 - k)));
            end
            if (rw) q.push_back(cyc_t'{bsy: 1'b1, en: 1'b0, we: 1'b0, a: 9'd0, d: 8'd0});
         end
      end
   end

   // Compare process: every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n && !ram_load) begin
         if (q.size() > 0) begin
            chk("busy", busy, q[0].bsy);
            chk("mfc", mfc, 1'b0);
            chk("ram_en", ram_en, q[0].en);
            chk("ram_we", ram_we, q[0].en & q[0].we);
            if (q[0].en) chk("ram_addr", ram_addr, q[0].a);
            if (q[0].en && q[0].we) chk("ram_wdata", ram_wdata, q[0].d);
         end else begin
            chk("busy", busy, 1'b0);
            chk("mfc", mfc, mdl_done);
            chk("ram_en", ram_en, 1'b0);
            chk("ram_we", ram_we, 1'b0);
            if (mdl_done) chk("err", err, exp_err);
         end
         chk("rdata", rdata, exp_rdata);
      end
   end

   task automatic reset_outputs_zero(input string tag);
      chk({tag, "_mfc"}, mfc, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_ram_en"}, ram_en, 1'b0);
      chk({tag, "_ram_we"}, ram_we, 1'b0);
      chk({tag, "_rdata"}, rdata, 32'h0);
      chk({tag, "_ram_addr"}, ram_addr, 9'h0);
      chk({tag, "_ram_wdata"}, ram_wdata, 8'h0);
   endtask

   // One request: drop mfa after edge drop_after (0 = keep), hold extra DONE cycles.
   task automatic req(input logic r, input logic [1:0] m, input logic [31:0] a,
                      input logic [31:0] d, input int drop_after, input int hold,
                      output int lat, output int encnt, output int width, output logic e);
      int edges;
      edges = 0;
      encnt = 0;
      mfa = 1'b1; rw = r; mas = m; addr = a; wdata = d;
      while (1) begin
         @(posedge clk); edges++; #1;
         if (drop_after > 0 && edges == drop_after) mfa = 1'b0;
         if (ram_en) encnt++;
         if (mfc) break;
         if (edges > 40) begin
            chk("mfc_timeout", mfc, 1'b1);
            break;
         end
      end
      lat = edges - 1;
      e = err;
      width = 1;
      if (mfa) begin
         repeat (hold) begin
            @(posedge clk); #1;
            if (mfc) width++;
         end
         mfa = 1'b0;
      end
      @(posedge clk); #1;
      while (mfc && width < 60) begin
         width++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int lat, enc, wid;
      logic e;
      logic [31:0] err_addr [3];
      logic [1:0]  err_mas  [3];
      err_addr[0] = 32'h011; err_mas[0] = 2'b10;
      err_addr[1] = 32'h013; err_mas[1] = 2'b01;
      err_addr[2] = 32'h010; err_mas[2] = 2'b11;

      repeat (2) @(posedge clk);
      #1 ram_load = 1'b0;
      reset_outputs_zero("rst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      req(1'b0, 2'b10, 32'h010, 32'hDEADBEEF, 0, 0, lat, enc, wid, e);
      chk("ww_lat", lat, 4); chk("ww_en_cycles", enc, 4); chk("ww_err", e, 1'b0);
      chk("ww_width", wid, 1);
      chk("ww_ram10", ram[9'h010], 8'hDE); chk("ww_ram11", ram[9'h011], 8'hAD);
      chk("ww_ram12", ram[9'h012], 8'hBE); chk("ww_ram13", ram[9'h013], 8'hEF);

      req(1'b1, 2'b10, 32'h010, 32'h0, 0, 0, lat, enc, wid, e);
      chk("wr_lat", lat, 5); chk("wr_rdata", rdata, 32'hDEADBEEF);

      req(1'b1, 2'b00, 32'h012, 32'h0, 0, 0, lat, enc, wid, e);
      chk("br_lat", lat, 2); chk("br_rdata", rdata, 32'h000000BE);

      req(1'b1, 2'b01, 32'h012, 32'h0, 0, 0, lat, enc, wid, e);
      chk("hr_lat", lat, 3); chk("hr_rdata", rdata, 32'h0000BEEF);

      req(1'b0, 2'b01, 32'h020, 32'h00001234, 0, 0, lat, enc, wid, e);
      chk("hw_lat", lat, 2);
      chk("hw_ram20", ram[9'h020], 8'h12); chk("hw_ram21", ram[9'h021], 8'h34);

      for (int i = 0; i < 3; i++) begin
         req(1'b1, err_mas[i], err_addr[i], 32'hFFFFFFFF, 0, 0, lat, enc, wid, e);
         chk("err_flag", e, 1'b1); chk("err_lat", lat, 1);
         chk("err_en_cycles", enc, 0); chk("err_rdata_kept", rdata, 32'h0000BEEF);
      end

      req(1'b0, 2'b00, 32'h040, 32'h000000AB, 0, 3, lat, enc, wid, e);
      chk("hold_width", wid, 4); chk("hold_en_cycles", enc, 1);
      chk("hold_ram40", ram[9'h040], 8'hAB);

      req(1'b0, 2'b10, 32'h050, 32'hCAFEF00D, 2, 0, lat, enc, wid, e);
      chk("drop_width", wid, 1); chk("drop_en_cycles", enc, 4);
      chk("drop_ram50", ram[9'h050], 8'hCA); chk("drop_ram51", ram[9'h051], 8'hFE);
      chk("drop_ram52", ram[9'h052], 8'hF0); chk("drop_ram53", ram[9'h053], 8'h0D);

      // Reset during beat 2 of a word write.
      mfa = 1'b1; rw = 1'b0; mas = 2'b10; addr = 32'h030; wdata = 32'h11223344;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0; mfa = 1'b0;
      #1;
      reset_outputs_zero("midrst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ram30", ram[9'h030], 8'h11); chk("rst_ram31", ram[9'h031], 8'h22);
      chk("rst_ram32", ram[9'h032], 8'h68); chk("rst_ram33", ram[9'h033], 8'h69);
      req(1'b1, 2'b10, 32'h010, 32'h0, 0, 0, lat, enc, wid, e);
      chk("post_rst_lat", lat, 5); chk("post_rst_rdata", rdata, 32'hDEADBEEF);

      for (int t = 0; t < 60; t++) begin
         logic        r, bad;
         logic [1:0]  m;
         logic [31:0] a, d;
         int          da, h, n, explat, expwid;
         r = 1'($urandom_range(0, 1));
         m = 2'($urandom_range(0, 3));
         a = $urandom;
         d = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (m == 2'd1) a[0] = 1'b0;
            if (m == 2'd2) a[1:0] = 2'b00;
         end
         da = $urandom_range(0, 3);
         h  = $urandom_range(0, 2);
         n  = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
         bad = (m == 2'd3) || (m == 2'd1 && a[0]) || (m == 2'd2 && a[1:0] != 2'b00);
         explat = bad ? 1 : (r ? n + 1 : n);
         expwid = (da > 0 && da <= explat + 1) ? 1 : 1 + h;
         req(r, m, a, d, da, h, lat, enc, wid, e);
         chk("rnd_lat", lat, explat);
         chk("rnd_err", e, bad);
         chk("rnd_width", wid, expwid);
         chk("rnd_en_cycles", enc, bad ? 0 : n);
      end

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 512; i++) chk("mem_image", ram[i], gold[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
